i3c_bus_arbiter: RTL and testbench

I3C_BUS_ARBITER -- requirements
Module: i3c_bus_arbiter

---
 rtl/i3c_bus_arbiter.sv | 110 +++++++++++
 tb/tb_i3c_bus_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/i3c_bus_arbiter.sv
// I3C bus arbiter: grants the bus to one of three engines (DAA, SDR, CCC/HDR) with START/STOP framing and a grant watchdog.
// Define I3C_ARB_RR_EN for round-robin arbitration; otherwise fixed priority bit0 > bit1 > bit2.
module i3c_bus_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_req,
  input  logic [2:0] i_done,
  input  logic       i_timer_bus_free_pure,
  output logic       o_start_pattern,
  output logic       o_stop_pattern,
  output logic [2:0] o_grant,
  output logic       o_busy,
  output logic       o_timeout
);

  typedef enum logic [2:0] {
    WAIT_FREE = 3'd0,
    READY     = 3'd1,
    START     = 3'd2,
    GRANTED   = 3'd3,
    STOP      = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q;
  logic [1:0]  winner;
  logic [15:0] wd_q;
  logic        timeout_q;
  logic [2:0]  grant_vec;
  logic        done_hit;
  logic        expire;
  logic        req_taken;

  assign grant_vec = 3'b001 << idx_q;
  // Only the owning engine's done bit can end the grant.
  assign done_hit  = |(i_done & grant_vec);
  assign expire    = (state_q == GRANTED) && !done_hit && (wd_q == TIMEOUT - 16'd1);
  assign req_taken = (state_q == READY) && (|i_req);

`ifdef I3C_ARB_RR_EN
  logic [1:0] rr_ptr_q;

  // Search begins one past the previous winner, wrapping modulo 3.
  always_comb begin
    winner = 2'd0;
    case (rr_ptr_q)
      2'd0:    winner = i_req[1] ? 2'd1 : (i_req[2] ? 2'd2 : 2'd0);
      2'd1:    winner = i_req[2] ? 2'd2 : (i_req[0] ? 2'd0 : 2'd1);
      default: winner = i_req[0] ? 2'd0 : (i_req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       rr_ptr_q <= 2'd2;
    else if (req_taken) rr_ptr_q <= winner;
  end
`else
  always_comb begin
    winner = i_req[0] ? 2'd0 : (i_req[1] ? 2'd1 : 2'd2);
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= WAIT_FREE;
      idx_q     <= 2'd0;
      wd_q      <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= expire;
      if (req_taken) idx_q <= winner;
      if (state_q == START)        wd_q <= 16'd0;
      else if (state_q == GRANTED) wd_q <= wd_q + 16'd1;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d         = state_q;
    o_start_pattern = 1'b0;
    o_stop_pattern  = 1'b1;
    o_grant         = 3'b000;
    o_busy          = 1'b0;
    case (state_q)
      WAIT_FREE: if (i_timer_bus_free_pure) state_d = READY;
      READY:     if (|i_req) state_d = START;
      START: begin
        o_start_pattern = 1'b1;
        o_stop_pattern  = 1'b0;
        o_busy          = 1'b1;
        state_d         = GRANTED;
      end
      GRANTED: begin
        o_stop_pattern = 1'b0;
        o_grant        = grant_vec;
        o_busy         = 1'b1;
        if (done_hit || expire) state_d = STOP;
      end
      STOP:    state_d = WAIT_FREE;
      default: state_d = WAIT_FREE;
    endcase
  end

  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_i3c_bus_arbiter.sv
// Directed bench for i3c_bus_arbiter: vector table plus hand-written watchdog, round-robin and reset sequences.
// Expected grants follow I3C_ARB_RR_EN when it is defined for the build.
module tb_i3c_bus_arbiter;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [2:0] i_req;
  logic [2:0] i_done;
  logic       i_timer_bus_free_pure;
  logic       o_start_pattern;
  logic       o_stop_pattern;
  logic [2:0] o_grant;
  logic       o_busy;
  logic       o_timeout;

  i3c_bus_arbiter #(.TIMEOUT(16'd20)) dut (
    .i_clk                 (i_clk),
    .i_rst_n               (i_rst_n),
    .i_req                 (i_req),
    .i_done                (i_done),
    .i_timer_bus_free_pure (i_timer_bus_free_pure),
    .o_start_pattern       (o_start_pattern),
    .o_stop_pattern        (o_stop_pattern),
    .o_grant               (o_grant),
    .o_busy                (o_busy),
    .o_timeout             (o_timeout)
  );

  always #10 i_clk = ~i_clk;

  // Output bundle: {start, stop, grant[2:0], busy, timeout}
  logic [6:0] outs;
  assign outs = {o_start_pattern, o_stop_pattern, o_grant, o_busy, o_timeout};

  localparam logic [6:0] IDLE_O    = 7'b0100000;
  localparam logic [6:0] START_O   = 7'b1000010;
  localparam logic [6:0] STOP_TO_O = 7'b0100001;

`ifdef I3C_ARB_RR_EN
  localparam logic [2:0] G2 = 3'b100;
`else
  localparam logic [2:0] G2 = 3'b010;
`endif

  function automatic logic [6:0] gnt_o(input logic [2:0] g);
    return {2'b00, g, 1'b1, 1'b0};
  endfunction

  typedef struct {
    logic [2:0] req;
    logic [2:0] done;
    logic       free;
    logic [6:0] exp;
    string      name;
  } vec_t;

  vec_t       vecs[14];
  logic [2:0] rr_exp[3];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input logic [2:0] req, input logic [2:0] done, input logic free);
    i_req                 = req;
    i_done                = done;
    i_timer_bus_free_pure = free;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{3'b000, 3'b000, 1'b0, IDLE_O,      "wf_hold"};
    vecs[1]  = '{3'b010, 3'b000, 1'b0, IDLE_O,      "wf_req_ignored"};
    vecs[2]  = '{3'b000, 3'b000, 1'b1, IDLE_O,      "to_ready"};
    vecs[3]  = '{3'b000, 3'b000, 1'b1, IDLE_O,      "ready_hold"};
    vecs[4]  = '{3'b010, 3'b000, 1'b1, START_O,     "start_sdr"};
    vecs[5]  = '{3'b000, 3'b000, 1'b0, gnt_o(3'b010), "grant_sdr_req_dropped"};
    vecs[6]  = '{3'b000, 3'b101, 1'b0, gnt_o(3'b010), "other_done_ignored"};
    vecs[7]  = '{3'b111, 3'b010, 1'b0, IDLE_O,      "stop_sdr"};
    vecs[8]  = '{3'b000, 3'b000, 1'b0, IDLE_O,      "wf_after_stop"};
    vecs[9]  = '{3'b110, 3'b000, 1'b1, IDLE_O,      "ready2"};
    vecs[10] = '{3'b110, 3'b000, 1'b0, START_O,     "start2"};
    vecs[11] = '{3'b000, 3'b000, 1'b0, gnt_o(G2),   "grant2"};
    vecs[12] = '{3'b000, G2,     1'b0, IDLE_O,      "stop2"};
    vecs[13] = '{3'b000, 3'b000, 1'b0, IDLE_O,      "wf2"};
`ifdef I3C_ARB_RR_EN
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100;
`else
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b001; rr_exp[2] = 3'b001;
`endif

    i_rst_n = 1'b0;
    i_req = 3'b000; i_done = 3'b000; i_timer_bus_free_pure = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_state", outs, IDLE_O);
    i_rst_n = 1'b1;

    // Vector table: framing, fixed latency, req/done filtering.
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].req, vecs[i].done, vecs[i].free);
      check(vecs[i].name, outs, vecs[i].exp);
    end

    // Three bus cycles with all engines requesting.
    for (int i = 0; i < 3; i++) begin
      step(3'b111, 3'b000, 1'b1);
      check("rr_ready", outs, IDLE_O);
      step(3'b111, 3'b000, 1'b1);
      check("rr_start", outs, START_O);
      step(3'b111, 3'b000, 1'b0);
      check("rr_grant", outs, gnt_o(rr_exp[i]));
      step(3'b111, rr_exp[i], 1'b0);
      check("rr_stop", outs, IDLE_O);
      step(3'b111, 3'b000, 1'b0);
      check("rr_wait_free", outs, IDLE_O);
    end

    // Watchdog expiry with only foreign done bits active.
    step(3'b001, 3'b000, 1'b1);
    step(3'b001, 3'b000, 1'b1);
    check("wd_start", outs, START_O);
    for (int k = 0; k < 20; k++) begin
      step(3'b000, 3'b110, 1'b0);
      check("wd_grant_held", outs, gnt_o(3'b001));
    end
    step(3'b000, 3'b110, 1'b0);
    check("wd_expire_stop", outs, STOP_TO_O);
    step(3'b000, 3'b000, 1'b0);
    check("wd_pulse_end", outs, IDLE_O);

    // Done coincident with expiry suppresses the timeout pulse.
    step(3'b001, 3'b000, 1'b1);
    step(3'b001, 3'b000, 1'b1);
    check("dx_start", outs, START_O);
    for (int k = 0; k < 20; k++) begin
      step(3'b000, 3'b000, 1'b0);
      check("dx_grant_held", outs, gnt_o(3'b001));
    end
    step(3'b000, 3'b001, 1'b0);
    check("done_at_expiry", outs, IDLE_O);
    step(3'b000, 3'b000, 1'b0);
    check("done_at_expiry_after", outs, IDLE_O);

    // Asynchronous reset in the middle of a grant.
    step(3'b001, 3'b000, 1'b1);
    step(3'b001, 3'b000, 1'b1);
    step(3'b000, 3'b000, 1'b0);
    check("pre_reset_grant", outs, gnt_o(3'b001));
    #2;
    i_rst_n = 1'b0;
    #1;
    check("async_reset_mid_grant", outs, IDLE_O);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step(3'b000, 3'b000, 1'b0);
    check("post_reset_wait_free", outs, IDLE_O);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
